// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte-stream program loader into instruction memory, then CPU run/halt control
// Optional XOR program checksum is built only when LOADER_CHECKSUM_EN is defined.
module instr_mem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start_load,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
    input  logic                  i_halt,
    output logic                  o_cpu_en,
    output logic                  o_loaded,
    output logic                  o_overflow,
    output logic [ADDR_WIDTH:0]   o_word_count,
    output logic [DATA_WIDTH-1:0] o_checksum
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BCW   = $clog2(BYTES);
    localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t                state;
    logic [BCW-1:0]        byte_cnt;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic                  is_halt_word;

    assign is_halt_word = &o_mem_wdata[DATA_WIDTH-1 -: 6];

    // The CPU owns the shared address port only while running.
    assign o_mem_addr = (state == S_RUN) ? i_fetch_addr : load_addr;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum;
    assign o_checksum = checksum;
`else
    assign o_checksum = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            byte_cnt     <= '0;
            load_addr    <= '0;
            o_rx_ready   <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_wdata  <= '0;
            o_cpu_en     <= 1'b0;
            o_loaded     <= 1'b0;
            o_overflow   <= 1'b0;
            o_word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (i_start_load) begin
                        state        <= S_RECV;
                        byte_cnt     <= '0;
                        load_addr    <= '0;
                        o_word_count <= '0;
                        o_loaded     <= 1'b0;
                        o_overflow   <= 1'b0;
                        o_rx_ready   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        checksum     <= '0;
`endif
                    end
                end
                S_RECV: begin
                    if (i_rx_valid) begin
                        o_mem_wdata <= {o_mem_wdata[DATA_WIDTH-9:0], i_rx_data};
                        byte_cnt    <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            state      <= S_WRITE;
                            o_rx_ready <= 1'b0;
                            o_mem_we   <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    o_mem_we     <= 1'b0;
                    byte_cnt     <= '0;
                    o_word_count <= o_word_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    checksum     <= checksum ^ o_mem_wdata;
`endif
                    if (is_halt_word) begin
                        state     <= S_RUN;
                        load_addr <= load_addr + 1'b1;
                        o_loaded  <= 1'b1;
                        o_cpu_en  <= 1'b1;
                    end else if (load_addr == LAST_ADDR) begin
                        // Memory full: hold the address rather than wrap onto word 0.
                        state      <= S_RUN;
                        o_loaded   <= 1'b1;
                        o_overflow <= 1'b1;
                        o_cpu_en   <= 1'b1;
                    end else begin
                        state      <= S_RECV;
                        load_addr  <= load_addr + 1'b1;
                        o_rx_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_halt) begin
                        state    <= S_HALTED;
                        o_cpu_en <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    o_rx_ready <= 1'b0;
                    o_mem_we   <= 1'b0;
                    o_cpu_en   <= 1'b0;
                end
            endcase
        end
    end

endmodule
